// File: rtl/smoldvi_link_ctrl.sv
// smoldvi_link_ctrl: bit-clock pixel-clock/symbol-strobe generator and DVI lane bring-up/shutdown sequencer.
// Every lane-enable edge is aligned to a serializer symbol load.
module smoldvi_link_ctrl #(
    parameter int START_CYCLES  = 1024,
    parameter int SETTLE_CYCLES = 4096,
    parameter int DRAIN_CYCLES  = 1024,
    parameter int CTR_W         = 13
) (
    input  logic clk_bit,
    input  logic rst_n_bit,
    input  logic en,
    output logic clk_pix,
    output logic ser_load,
    output logic clk_lane_en,
    output logic data_lane_en,
    output logic link_up
);
    typedef enum logic [2:0] {OFF, START, CLK_ONLY, ACTIVE, DRAIN} state_t;
    localparam logic [CTR_W-1:0] START_LD  = CTR_W'(START_CYCLES - 1);
    localparam logic [CTR_W-1:0] SETTLE_LD = CTR_W'(SETTLE_CYCLES - 1);
    localparam logic [CTR_W-1:0] DRAIN_LD  = CTR_W'(DRAIN_CYCLES - 1);
    logic [2:0] ph, ph_n;
    logic en_m, en_s;
    state_t state, state_n;
    logic [CTR_W-1:0] dly, dly_n;
    logic dly_z;
    assign ph_n  = (ph == 3'd4) ? 3'd0 : ph + 3'd1;
    assign dly_z = (dly == '0);
    always_ff @(posedge clk_bit or negedge rst_n_bit) begin
        if (!rst_n_bit) begin
            ph           <= 3'd0;
            clk_pix      <= 1'b0;
            ser_load     <= 1'b0;
            en_m         <= 1'b0;
            en_s         <= 1'b0;
            state        <= OFF;
            dly          <= '0;
            clk_lane_en  <= 1'b0;
            data_lane_en <= 1'b0;
            link_up      <= 1'b0;
        end else begin
            ph           <= ph_n;
            clk_pix      <= (ph_n >= 3'd1) && (ph_n <= 3'd3);
            ser_load     <= (ph_n == 3'd0);
            en_m         <= en;
            en_s         <= en_m;
            state        <= state_n;
            dly          <= dly_n;
            clk_lane_en  <= (state_n == CLK_ONLY) || (state_n == ACTIVE) || (state_n == DRAIN);
            data_lane_en <= (state_n == ACTIVE);
            link_up      <= (state_n == ACTIVE);
        end
    end
    // dly reloads on every state entry, otherwise counts down and holds at zero
    always_comb begin
        state_n = state;
        dly_n   = dly_z ? dly : dly - 1'b1;
        case (state)
            OFF: if (en_s) begin
                state_n = START;
                dly_n   = START_LD;
            end
            START: if (!en_s) begin
                state_n = OFF;
                dly_n   = '0;
            end else if (dly_z && ser_load) begin
                state_n = CLK_ONLY;
                dly_n   = SETTLE_LD;
            end
            CLK_ONLY: if (!en_s) begin
                state_n = DRAIN;
                dly_n   = DRAIN_LD;
            end else if (dly_z && ser_load) begin
                state_n = ACTIVE;
                dly_n   = '0;
            end
            ACTIVE: if (!en_s && ser_load) begin
                state_n = DRAIN;
                dly_n   = DRAIN_LD;
            end
            DRAIN: if (dly_z && ser_load) begin
                state_n = OFF;
                dly_n   = '0;
            end
            default: begin
                state_n = OFF;
                dly_n   = '0;
            end
        endcase
    end
endmodule
